// File: rtl/uart_loader_pkg.sv
// Shared types and lane constants for the UART instruction loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int LANE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/uart_loader_gap_timer.sv
// Inter-byte gap timer: pulses expired once TIMEOUT_CYCLES-1 armed cycles follow a restart.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic arm,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !arm || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = arm && !restart && (cnt_q == LAST);

endmodule

// File: rtl/uart_loader.sv
// Packs UART bytes into little-endian words and writes them to instruction memory.
// Optional running byte checksum enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic [7:0]            checksum
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH:0]   WC_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
    return (v == WC_MAX) ? v : v + (ADDR_WIDTH + 1)'(1);
  endfunction

  state_e                  state_q, state_d;
  logic [LANE_IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]        buf_q, buf_d;
  logic [WIDTH-1:0]        wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic                    full_q, full_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, done_q;
  logic                    byte_ok, load_start, full_now, arm, expired;

  assign byte_ok    = rx_done && (state_q == ST_RECV);
  assign load_start = (state_q == ST_IDLE) || ((state_q == ST_DONE) && load_en);
  assign arm        = (state_q == ST_RECV) && (idx_q != '0);
  // A byte landing while the last-address write is still on the bus already overflows.
  assign full_now   = full_q || (wr_en_q && (addr_q == ADDR_MAX));

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(byte_ok),
    .arm    (arm),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;

    if (wr_en_q) begin
      cnt_d = sat_inc(cnt_q);
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + ADDR_WIDTH'(1);
    end

    if (load_start) begin
      idx_d  = '0;
      buf_d  = '0;
      addr_d = '0;
      cnt_d  = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_en) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (rx_done) begin
          if (full_now) begin
            ovf_d = 1'b1;
          end else if (idx_q == LAST_LANE) begin
            wr_en_d   = 1'b1;
            wr_data_d = {rx_data, buf_q[WIDTH-BYTE_W-1:0]};
            buf_d     = '0;
            idx_d     = '0;
          end else begin
            buf_d[BYTE_W*idx_q +: BYTE_W] = rx_data;
            idx_d = idx_q + LANE_IDX_W'(1);
          end
        end
        if (!load_en)     state_d = (idx_d != '0) ? ST_FLUSH : ST_DONE;
        else if (expired) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Unfilled upper lanes are already zero: the buffer is cleared after every write.
        wr_en_d   = 1'b1;
        wr_data_d = buf_q;
        buf_d     = '0;
        idx_d     = '0;
        state_d   = load_en ? ST_RECV : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      wr_data_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d == ST_RECV) || (state_d == ST_FLUSH);
      done_q    <= (state_d == ST_DONE);
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n)          sum_q <= '0;
    else if (load_start) sum_q <= '0;
    else if (byte_ok)    sum_q <= sum_q + rx_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: a byte-stream model predicts every memory write and its cycle.
module tb_uart_loader;

  localparam int AW = 8;
  localparam int TO = 100;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, load_en, rx_done;
  logic [7:0]    rx_data;
  logic          wr_en, busy, done, overflow;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;
  logic [7:0]    checksum;

  logic          load_en2, rx_done2;
  logic [7:0]    rx_data2;
  logic          wr_en2, busy2, done2, overflow2;
  logic [1:0]    wr_addr2;
  logic [31:0]   wr_data2;
  logic [2:0]    word_count2;
  logic [7:0]    checksum2;

  uart_loader #(.WIDTH(32), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .word_count(word_count), .overflow(overflow), .checksum(checksum)
  );

  uart_loader #(.WIDTH(32), .ADDR_WIDTH(2), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en2), .rx_data(rx_data2), .rx_done(rx_done2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2), .done(done2),
    .word_count(word_count2), .overflow(overflow2), .checksum(checksum2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cmp_e;
  logic [31:0] mem [256];
  logic [31:0] mem2 [4];
  int          wr2_addr [8];
  int          wr2_n = 0;

  // Model: bytes fill lanes low-first; a full word is written one cycle after its
  // last byte, a load-end flush two cycles after load_en drops, a timeout flush
  // TIMEOUT_CYCLES+2 cycles after the last byte was presented.
  int          m_lane;
  logic [31:0] m_word;
  int          m_addr;
  int          m_sum;

  function automatic void m_start();
    m_lane = 0;
    m_word = '0;
    m_addr = 0;
    m_sum  = 0;
  endfunction

  function automatic void m_emit(input int c);
    wr_t w;
    w.cyc  = c;
    w.addr = m_addr[7:0];
    w.data = m_word;
    exp_q.push_back(w);
    if (m_addr < (1 << AW) - 1) m_addr = m_addr + 1;
    m_word = '0;
    m_lane = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b, input int c);
    m_sum = (m_sum + int'(b)) % 256;
    m_word[8*m_lane +: 8] = b;
    m_lane = m_lane + 1;
    if (m_lane == 4) m_emit(c + 1);
  endfunction

  function automatic void m_end_load(input int c);
    if (m_lane != 0) m_emit(c + 2);
  endfunction

  function automatic void m_idle_timeout(input int c);
    if (m_lane != 0) m_emit(c + TO + 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    m_byte(b, cyc);
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    rx_data2 = b;
    rx_done2 = 1'b1;
    tick();
    rx_done2 = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wr_missing: got no write by cycle %0d expected addr %0h data %0h at cycle %0d",
               cyc, exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (wr_en === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL wr_unexpected: got addr %0h data %0h at cycle %0d expected no write",
                 wr_addr, wr_data, cyc);
      end else begin
        cmp_e = exp_q.pop_front();
        if (cmp_e.cyc != cyc || cmp_e.addr !== wr_addr || cmp_e.data !== wr_data) begin
          errors = errors + 1;
          $display("FAIL wr_match: got cyc %0d addr %0h data %0h expected cyc %0d addr %0h data %0h",
                   cyc, wr_addr, wr_data, cmp_e.cyc, cmp_e.addr, cmp_e.data);
        end
      end
      mem[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (wr_en2 === 1'b1) begin
      if (wr2_n < 8) wr2_addr[wr2_n] = int'(wr_addr2);
      mem2[wr_addr2] = wr_data2;
      wr2_n = wr2_n + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] t2 [5];
    int c;
    t1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    t2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};

    rst_n = 1'b0; load_en = 1'b0; rx_done = 1'b0; rx_data = '0;
    load_en2 = 1'b0; rx_done2 = 1'b0; rx_data2 = '0;
    m_start();
    tick();
    tick();

    chk("rst_wr_en",      64'(wr_en),      64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_done",       64'(done),       64'(0));
    chk("rst_overflow",   64'(overflow),   64'(0));
    chk("rst_wr_addr",    64'(wr_addr),    64'(0));
    chk("rst_wr_data",    64'(wr_data),    64'(0));
    chk("rst_word_count", 64'(word_count), 64'(0));
    chk("rst_checksum",   64'(checksum),   64'(0));
    chk("rst_wr_en2",     64'(wr_en2),     64'(0));
    rst_n = 1'b1;
    tick();

    // Two full words with load_en held high
    load_en = 1'b1; m_start(); tick();
    chk("t1_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 8; i++) send(t1[i]);
    repeat (3) tick();
    chk("t1_word_count", 64'(word_count), 64'(2));
    chk("t1_wr_addr",    64'(wr_addr),    64'(2));
    chk("t1_mem0",       64'(mem[0]),     64'h0000_0013);
    chk("t1_mem1",       64'(mem[1]),     64'h0010_0093);
    load_en = 1'b0; m_end_load(cyc); tick(); tick();
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_busy_low", 64'(busy), 64'(0));

    // Six bytes, load_en falls with the last one
    load_en = 1'b1; m_start(); tick();
    chk("t2_wc_clear",   64'(word_count), 64'(0));
    chk("t2_addr_clear", 64'(wr_addr),    64'(0));
    chk("t2_done_low",   64'(done),       64'(0));
    for (int i = 0; i < 5; i++) send(t2[i]);
    load_en = 1'b0; c = cyc; send(8'h22); m_end_load(c);
    repeat (4) tick();
    chk("t2_done",       64'(done),       64'(1));
    chk("t2_word_count", 64'(word_count), 64'(2));
    chk("t2_mem0",       64'(mem[0]),     64'hDDCC_BBAA);
    chk("t2_mem1",       64'(mem[1]),     64'h0000_2211);
    repeat (5) tick();
    chk("t2_hold_addr", 64'(wr_addr),    64'(2));
    chk("t2_hold_wc",   64'(word_count), 64'(2));

    // Partial word flushed by inter-byte timeout, then loading continues
    load_en = 1'b1; m_start(); tick();
    send(8'h5A); c = cyc; send(8'hA5); m_idle_timeout(c);
    repeat (TO) tick();
    chk("t3_no_early_write", 64'(word_count), 64'(0));
    repeat (4) tick();
    chk("t3_word_count", 64'(word_count), 64'(1));
    chk("t3_busy",       64'(busy),       64'(1));
    chk("t3_done_low",   64'(done),       64'(0));
    chk("t3_mem0",       64'(mem[0]),     64'h0000_A55A);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    repeat (3) tick();
    chk("t3_mem1", 64'(mem[1]),     64'h0403_0201);
    chk("t3_wc2",  64'(word_count), 64'(2));
    load_en = 1'b0; m_end_load(cyc); repeat (2) tick();
    chk("t3_done", 64'(done), 64'(1));

    // Checksum wraps mod 256
    load_en = 1'b1; m_start(); tick();
    send(8'hFF); load_en = 1'b0; c = cyc; send(8'h02); m_end_load(c);
    repeat (4) tick();
    chk("t4_checksum",       64'(checksum), CSUM ? 64'h01 : 64'h00);
    chk("t4_checksum_model", 64'(checksum), CSUM ? 64'(m_sum) : 64'(0));
    chk("t4_mem0",           64'(mem[0]),   64'h0000_02FF);
    chk("t4_done",           64'(done),     64'(1));

    // Reset in the middle of a word discards it
    load_en = 1'b1; m_start(); tick();
    send(8'h11); send(8'h22); send(8'h33);
    rst_n = 1'b0; load_en = 1'b0; m_start(); tick();
    chk("t5_wr_en",       64'(wr_en),      64'(0));
    chk("t5_busy",        64'(busy),       64'(0));
    chk("t5_done",        64'(done),       64'(0));
    chk("t5_wr_data",     64'(wr_data),    64'(0));
    chk("t5_word_count",  64'(word_count), 64'(0));
    chk("t5_checksum",    64'(checksum),   64'(0));
    rst_n = 1'b1; repeat (3) tick();
    chk("t5_no_write", 64'(wr_en), 64'(0));

    // Four-word memory: 20 bytes overflow it
    load_en2 = 1'b1; tick();
    for (int i = 0; i < 16; i++) send2(8'(i));
    tick();
    chk("t6_overflow_pre", 64'(overflow2), 64'(0));
    for (int i = 16; i < 20; i++) send2(8'(i));
    repeat (3) tick();
    chk("t6_writes", 64'(wr2_n), 64'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("t6_addr%0d", k), 64'(wr2_addr[k]), 64'(k));
    chk("t6_overflow",   64'(overflow2),   64'(1));
    chk("t6_word_count", 64'(word_count2), 64'(4));
    chk("t6_wr_addr",    64'(wr_addr2),    64'(3));
    chk("t6_mem3",       64'(mem2[3]),     64'h0F0E_0D0C);
    chk("t6_checksum",   64'(checksum2),   CSUM ? 64'hBE : 64'h00);
    load_en2 = 1'b0; repeat (2) tick();
    chk("t6_done", 64'(done2), 64'(1));

    chk("exp_drain", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
